// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: fetch run-state encoding and default address/word widths
// shared by the ROM, decoder and fetch stage.
package inst_fetch_pkg;
    localparam int A_DEF = 16;
    localparam int W_DEF = 9;
    typedef enum logic [1:0] {FS_IDLE = 2'd0, FS_RUN = 2'd1, FS_DONE = 2'd2} fetch_state_e;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, one-entry fetch register and idle/run/done control
// for the instruction ROM interface.
module inst_fetch import inst_fetch_pkg::*; #(
    parameter int A = A_DEF,
    parameter int W = W_DEF
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    output logic [A-1:0] InstAddress,
    input  logic [W-1:0] InstIn,
    output logic [W-1:0] InstReg,
    output logic [A-1:0] InstPC,
    output logic         InstValid,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic         BranchRel,
    input  logic [A-1:0] BranchTarget,
    input  logic         Halt,
    output logic         Done
);
    fetch_state_e state;
    logic [A-1:0] pc;
    logic [A-1:0] target;

    assign target = BranchRel ? InstPC + BranchTarget : BranchTarget;
    assign InstAddress = pc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= FS_IDLE;
            pc        <= '0;
            InstReg   <= '0;
            InstPC    <= '0;
            InstValid <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                FS_IDLE, FS_DONE: begin
                    if (Start) begin
                        pc    <= StartAddr;
                        Done  <= 1'b0;
                        state <= FS_RUN;
                    end
                end
                FS_RUN: begin
                    if (Halt && InstValid) begin
                        state     <= FS_DONE;
                        InstValid <= 1'b0;
                        Done      <= 1'b1;
                    end else if (BranchEn && InstValid) begin
                        // squash the word fetched this cycle; the target arrives next cycle
                        pc        <= target;
                        InstValid <= 1'b0;
                    end else if (!Stall) begin
                        InstReg   <= InstIn;
                        InstPC    <= pc;
                        InstValid <= 1'b1;
                        pc        <= pc + A'(1);
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plan plus randomized traffic, checked every cycle
// against a behavioural model of the fetch stage.
module tb_inst_fetch;
    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [15:0] StartAddr;
    logic [15:0] InstAddress;
    logic [8:0]  InstIn;
    logic [8:0]  InstReg;
    logic [15:0] InstPC;
    logic        InstValid;
    logic        Stall;
    logic        BranchEn;
    logic        BranchRel;
    logic [15:0] BranchTarget;
    logic        Halt;
    logic        Done;

    int checks = 0;
    int failures = 0;

    logic [8:0] rom [65536];

    int          m_mode;
    logic [15:0] m_pc;
    logic [8:0]  m_reg;
    logic [15:0] m_ipc;
    logic        m_val;
    logic        m_done;

    inst_fetch #(.A(16), .W(9)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .InstAddress(InstAddress), .InstIn(InstIn), .InstReg(InstReg), .InstPC(InstPC),
        .InstValid(InstValid), .Stall(Stall), .BranchEn(BranchEn), .BranchRel(BranchRel),
        .BranchTarget(BranchTarget), .Halt(Halt), .Done(Done)
    );

    assign InstIn = rom[InstAddress];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 done; one step per accepted clock edge.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_mode = 0; m_pc = 16'h0; m_reg = 9'h0; m_ipc = 16'h0; m_val = 1'b0; m_done = 1'b0;
        end else if (m_mode != 1) begin
            if (Start) begin
                m_mode = 1; m_pc = StartAddr; m_done = 1'b0;
            end
        end else if (m_val && Halt) begin
            m_mode = 2; m_val = 1'b0; m_done = 1'b1;
        end else if (m_val && BranchEn) begin
            m_pc = BranchRel ? 16'((32'(m_ipc) + 32'(BranchTarget)) % 65536) : BranchTarget;
            m_val = 1'b0;
        end else if (!Stall) begin
            m_reg = rom[m_pc]; m_ipc = m_pc; m_val = 1'b1;
            m_pc = 16'((32'(m_pc) + 1) % 65536);
        end
        #1;
        chk("InstAddress", 32'(InstAddress), 32'(m_pc));
        chk("InstReg", 32'(InstReg), 32'(m_reg));
        chk("InstPC", 32'(InstPC), 32'(m_ipc));
        chk("InstValid", 32'(InstValid), 32'(m_val));
        chk("Done", 32'(Done), 32'(m_done));
    end

    task automatic cyc(input logic st, input logic [15:0] sa, input logic sl, input logic be,
                       input logic br, input logic [15:0] bt, input logic hl);
        Start = st; StartAddr = sa; Stall = sl; BranchEn = be; BranchRel = br;
        BranchTarget = bt; Halt = hl;
        @(posedge Clk);
        #2;
        Start = 0; StartAddr = 0; Stall = 0; BranchEn = 0; BranchRel = 0; BranchTarget = 0; Halt = 0;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom);
        Reset_n = 0;
        Start = 0; StartAddr = 0; Stall = 0; BranchEn = 0; BranchRel = 0; BranchTarget = 0; Halt = 0;
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1;
        chk("reset_valid", 32'(InstValid), 0);
        chk("reset_addr", 32'(InstAddress), 0);
        cyc(1, 16'h0010, 0, 0, 0, 0, 0);
        chk("start_addr", 32'(InstAddress), 32'h10);
        chk("start_novalid", 32'(InstValid), 0);
        nop();
        chk("first_pc", 32'(InstPC), 32'h10);
        chk("first_word", 32'(InstReg), 32'(rom[16'h0010]));
        chk("first_valid", 32'(InstValid), 1);
        nop();
        chk("second_pc", 32'(InstPC), 32'h11);
        nop();
        chk("third_pc", 32'(InstPC), 32'h12);
        repeat (2) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            chk("stall_pc", 32'(InstPC), 32'h12);
            chk("stall_addr", 32'(InstAddress), 32'h13);
            chk("stall_word", 32'(InstReg), 32'(rom[16'h0012]));
        end
        nop();
        chk("resume_pc", 32'(InstPC), 32'h13);
        chk("resume_addr", 32'(InstAddress), 32'h14);
        cyc(0, 0, 0, 1, 0, 16'h0020, 0);
        nop();
        chk("abs20_pc", 32'(InstPC), 32'h20);
        cyc(0, 0, 0, 1, 1, 16'hFFFC, 0);
        chk("rel_bubble", 32'(InstValid), 0);
        nop();
        chk("rel_pc", 32'(InstPC), 32'h1C);
        chk("rel_valid", 32'(InstValid), 1);
        cyc(0, 0, 0, 1, 0, 16'h0100, 0);
        chk("abs_bubble", 32'(InstValid), 0);
        nop();
        chk("abs_pc", 32'(InstPC), 32'h100);
        cyc(0, 0, 1, 1, 0, 16'h0200, 1);
        chk("halt_prio_done", 32'(Done), 1);
        chk("halt_prio_valid", 32'(InstValid), 0);
        chk("halt_prio_addr", 32'(InstAddress), 32'h101);
        nop();
        chk("done_hold", 32'(Done), 1);
        cyc(1, 16'h0005, 0, 0, 0, 0, 0);
        chk("restart_done", 32'(Done), 0);
        chk("restart_addr", 32'(InstAddress), 32'h5);
        nop();
        chk("restart_pc", 32'(InstPC), 32'h5);
        cyc(0, 0, 1, 1, 0, 16'h0040, 0);
        chk("br_over_stall_addr", 32'(InstAddress), 32'h40);
        chk("br_over_stall_valid", 32'(InstValid), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("halt_ignored_done", 32'(Done), 0);
        chk("halt_ignored_pc", 32'(InstPC), 32'h40);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("halt_taken", 32'(Done), 1);
        cyc(1, 16'hFFFF, 0, 0, 0, 0, 0);
        nop();
        chk("wrap_pc0", 32'(InstPC), 32'hFFFF);
        chk("wrap_addr", 32'(InstAddress), 32'h0);
        nop();
        chk("wrap_pc1", 32'(InstPC), 32'h0);
        @(posedge Clk);
        #3 Reset_n = 0;
        #1;
        chk("async_addr", 32'(InstAddress), 0);
        chk("async_reg", 32'(InstReg), 0);
        chk("async_pc", 32'(InstPC), 0);
        chk("async_valid", 32'(InstValid), 0);
        chk("async_done", 32'(Done), 0);
        @(posedge Clk);
        #2 Reset_n = 1;
        for (int n = 0; n < 4000; n++)
            cyc(($urandom % 8) == 0, 16'($urandom), ($urandom % 4) == 0, ($urandom % 6) == 0,
                1'($urandom), 16'($urandom), ($urandom % 30) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
